// File: rtl/opsel_pkg.sv
// Shared definitions for the operand/writeback select stage: source indices,
// the source-count limit and the select legality helper.
package opsel_pkg;

  localparam int SRC_PCIMM     = 0;
  localparam int SRC_REG       = 1;
  localparam int SRC_DMEM      = 2;
  localparam int SRC_WB        = 3;
  localparam int OPSEL_MAX_SRC = 16;

  function automatic logic opsel_sel_legal(input int sel, input int num_src);
    return sel < num_src;
  endfunction

endpackage

// File: rtl/opsel_skid_buf.sv
// Generic two-entry valid/ready skid buffer: a main register drives the outputs,
// and a skid register catches the one beat accepted while the output is stalled.
module opsel_skid_buf #(
  parameter int DW = 34
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef struct packed {
    logic [DW-1:0] payload;
    logic          valid;
  } beat_t;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  logic  accept;
  logic  main_load;

  // Ready depends only on registered state, so out_ready never reaches in_ready.
  assign in_ready  = !skid_q.valid && !rst;
  assign accept    = in_valid && in_ready;
  assign main_load = !main_q.valid || out_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns main_d/skid_d and no latch is inferred.
    main_d = main_q;
    skid_d = skid_q;
    if (main_load) begin
      if (skid_q.valid) begin
        // in_ready is low whenever the skid is full, so no accept collides here.
        main_d       = skid_q;
        skid_d.valid = 1'b0;
      end else if (accept) begin
        main_d = '{payload: in_payload, valid: 1'b1};
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d = '{payload: in_payload, valid: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payloads are cleared too, since the outputs must read zero after reset.
      main_q <= '0;
      skid_q <= '0;
    end else begin
      // NOTE: non-blocking so both registers update from the same pre-edge state.
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_payload = main_q.payload;
  assign out_valid   = main_q.valid;

endmodule

// File: rtl/operand_sel_pipe.sv
// N-source operand/writeback select with a registered skid-buffered output.
// Define OPSEL_ERR_CHECK_EN to enable the sticky illegal-select flag and X checks.
module operand_sel_pipe #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_SRC = 4,
  localparam int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err
);

  import opsel_pkg::*;

  localparam int DW = WIDTH + SEL_W;

  if (NUM_SRC < 2 || NUM_SRC > OPSEL_MAX_SRC) begin : g_bad_num_src
    $error("operand_sel_pipe: NUM_SRC must be in 2..%0d", OPSEL_MAX_SRC);
  end

  logic [WIDTH-1:0] sel_data;
  logic [DW-1:0]    out_payload;

  // Selects with no matching source fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_sel == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  opsel_skid_buf #(.DW(DW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_payload  ({sel_data, in_sel}),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_payload (out_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  assign {out_data, out_src} = out_payload;

`ifdef OPSEL_ERR_CHECK_EN
  logic sel_err_q, sel_err_d;

  assign sel_err_d = sel_err_q ||
                     (in_valid && in_ready && !opsel_sel_legal(32'(in_sel), NUM_SRC));

  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

`ifndef SYNTHESIS
  sel_known_a: assert property (@(posedge clk) disable iff (rst)
                                in_valid |-> !$isunknown(in_sel));
`endif
`else
  assign sel_err = 1'b0;
`endif

endmodule
